shift_register_param_muxed: RTL and testbench

SHIFT_REGISTER_PARAM_MUXED -- requirements
Module: shift_register_param_muxed

---
 rtl/shift_register_param_muxed.sv | 66 ++++++
 tb/tb_shift_register_param_muxed.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_param_muxed.sv
// rtl/shift_register_param_muxed.sv - loadable bidirectional shift register with shift counter and done pulse
// Optional rotate feature: define SHIFT_REG_ROTATE_EN to recirculate the outgoing bit as the fill bit.
module shift_register_param_muxed #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             load,
   input  logic             dir,
   input  logic             serial_in,
   input  logic             rotate,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic fill;

   always_comb begin
      serial_out = dir ? q[0] : q[WIDTH-1];
   end

`ifdef SHIFT_REG_ROTATE_EN
   always_comb begin
      fill = rotate ? serial_out : serial_in;
   end
`else
   logic unused_rotate;
   assign unused_rotate = rotate;

   always_comb begin
      fill = serial_in;
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q     <= '0;
         count <= '0;
         done  <= 1'b0;
      end else if (!enable) begin
         done <= 1'b0;
      end else if (load) begin
         q     <= d;
         count <= '0;
         done  <= 1'b0;
      end else begin
         q <= dir ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
         // Wrap on the WIDTH-th shift and flag a full-word transfer for one cycle
         if (count < LAST) begin
            count <= count + 1'b1;
            done  <= 1'b0;
         end else begin
            count <= '0;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shift_register_param_muxed.sv
// tb/tb_shift_register_param_muxed.sv - directed and randomized checks against a word-level reference model
module tb_shift_register_param_muxed;

   logic        clk = 1'b0;
   logic        clk_run = 1'b0;
   logic        resetn = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic        dir = 1'b0;
   logic        serial_in = 1'b0;
   logic        rotate = 1'b0;
   logic [15:0] d = '0;
   logic [15:0] q;
   logic        serial_out;
   logic [4:0]  count;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_q;
   int          m_n;
   logic        m_done;

   shift_register_param_muxed #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .load(load), .dir(dir),
      .serial_in(serial_in), .rotate(rotate), .d(d), .q(q),
      .serial_out(serial_out), .count(count), .done(done)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q = '0;
      m_n = 0;
      m_done = 1'b0;
   endtask

   // Word-level view: a shift is multiply/divide by two plus the fill weight
   task automatic model_edge();
      int fill;
      int outgoing;
      if (!enable) begin
         m_done = 1'b0;
      end else if (load) begin
         m_q = d;
         m_n = 0;
         m_done = 1'b0;
      end else begin
         outgoing = dir ? (int'(m_q) % 2) : (int'(m_q) / 32768);
         fill = int'(serial_in);
`ifdef SHIFT_REG_ROTATE_EN
         if (rotate) fill = outgoing;
`endif
         if (dir) m_q = 16'(int'(m_q) / 2 + fill * 32768);
         else     m_q = 16'((int'(m_q) * 2 + fill) % 65536);
         m_n++;
         m_done = (m_n % 16 == 0);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".q"}, 32'(q), 32'(m_q));
      check({tag, ".count"}, 32'(count), 32'(m_n % 16));
      check({tag, ".done"}, 32'(done), 32'(m_done));
      check({tag, ".sout"}, 32'(serial_out), dir ? 32'(m_q[0]) : 32'(m_q[15]));
   endtask

   task automatic do_load(input logic [15:0] v);
      enable = 1'b1; load = 1'b1; d = v;
      cyc("load");
      load = 1'b0;
   endtask

   initial begin
      #3 resetn = 1'b0;
      #1;
      model_reset();
      check("rst_q", 32'(q), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      #2 resetn = 1'b1;
      clk_run = 1'b1;

      // left shifts with fill 1
      do_load(16'hA5C3);
      dir = 1'b0; serial_in = 1'b1;
      for (int i = 0; i < 3; i++) cyc("shl");
      check("sout_before_4th", 32'(serial_out), 32'h0);
      cyc("shl");
      check("shl4_q", 32'(q), 32'h5C3F);
      check("shl4_count", 32'(count), 32'd4);
      check("shl4_done", 32'(done), 32'h0);

      // full word of right shifts
      do_load(16'h8001);
      dir = 1'b1; serial_in = 1'b0;
      for (int i = 0; i < 15; i++) cyc("shr");
      check("shr15_done", 32'(done), 32'h0);
      cyc("shr");
      check("shr16_q", 32'(q), 32'h0);
      check("shr16_count", 32'(count), 32'h0);
      check("shr16_done", 32'(done), 32'h1);
      enable = 1'b0;
      cyc("after16");
      check("after16_done", 32'(done), 32'h0);

      // hold with enable low
      do_load(16'h1234);
      enable = 1'b0; load = 1'b1; d = 16'hFFFF;
      for (int i = 0; i < 3; i++) cyc("hold");
      check("hold_q", 32'(q), 32'h1234);
      check("hold_count", 32'(count), 32'h0);
      load = 1'b0;

      // rotate request
      do_load(16'h8001);
      rotate = 1'b1; dir = 1'b0; serial_in = 1'b0;
      cyc("rot");
`ifdef SHIFT_REG_ROTATE_EN
      check("rot_q", 32'(q), 32'h0003);
`else
      check("rot_q", 32'(q), 32'h0002);
`endif
      rotate = 1'b0;

      // reset between edges, mid sequence
      do_load(16'hFFFF);
      for (int i = 0; i < 7; i++) cyc("pre_rst");
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check("midrst_q", 32'(q), 32'h0);
      check("midrst_count", 32'(count), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      #1 resetn = 1'b1;
      do_load(16'h00F0);
      check("postrst_q", 32'(q), 32'h00F0);
      check("postrst_count", 32'(count), 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         enable    = ($urandom_range(0, 9) != 0);
         load      = ($urandom_range(0, 19) == 0);
         dir       = 1'($urandom);
         serial_in = 1'($urandom);
         rotate    = 1'($urandom);
         d         = 16'($urandom);
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
